clearable_ram: RTL and testbench

CLEARABLE_RAM -- requirements
Module: clearable_ram

---
 rtl/ram_pkg.sv | 12 +
 rtl/clear_sequencer.sv | 56 +++++
 rtl/clearable_ram.sv | 67 ++++++
 tb/tb_clearable_ram.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and default geometry for the clearable RAM.
package ram_pkg;

   localparam int DEFAULT_WIDTH     = 16;
   localparam int DEFAULT_ADDR_BITS = 9;

   typedef enum logic {
      IDLE,
      CLEARING
   } sweep_state_e;

endpackage

// File: rtl/clear_sequencer.sv
// Walks a counter across every address once per accepted clear request,
// raising busy for the sweep and pulsing done in the cycle after it ends.
module clear_sequencer
   import ram_pkg::*;
#(
   parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_BITS-1:0] sweep_addr,
   output logic                 sweep_we
);

   localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

   sweep_state_e         state_q;
   logic [ADDR_BITS-1:0] cnt_q;
   logic                 done_q;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register in this block samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CLEARING;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (clear) begin
                  state_q <= CLEARING;
                  cnt_q   <= '0;
               end
            end
            CLEARING: begin
               // Counter wraps to 0 on the final write, leaving it ready for the next sweep.
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_ADDR) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign busy       = (state_q == CLEARING);
   assign sweep_we   = (state_q == CLEARING);
   assign sweep_addr = cnt_q;
   assign done       = done_q;

endmodule

// File: rtl/clearable_ram.sv
// Single-port RAM with combinational read and a hardware sweep that zeroes
// every word; user writes are locked out while the sweep runs.
module clearable_ram
   import ram_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     in,
   input  logic                 load,
   input  logic [ADDR_BITS-1:0] address,
   input  logic                 clear,
   output logic [WIDTH-1:0]     out,
   output logic                 busy,
   output logic                 done
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic                 sweep_we;
   logic [ADDR_BITS-1:0] sweep_addr;
   logic                 user_we;
   logic                 wr_en;
   logic [ADDR_BITS-1:0] wr_addr;
   logic [WIDTH-1:0]     wr_data;

   clear_sequencer #(
      .ADDR_BITS (ADDR_BITS)
   ) u_seq (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .busy       (busy),
      .done       (done),
      .sweep_addr (sweep_addr),
      .sweep_we   (sweep_we)
   );

   // An edge that accepts a clear (or reset) starts the sweep and drops the user write.
   assign user_we = load & ~busy & ~clear & ~reset;

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      wr_en   = user_we;
      wr_addr = address;
      wr_data = in;
      if (sweep_we) begin
         wr_en   = 1'b1;
         wr_addr = sweep_addr;
         wr_data = '0;
      end
   end

   // NOTE: the array has no reset branch; it is zeroed by the sweep that reset starts,
   // which keeps it mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign out = busy ? '0 : mem_q[address];

endmodule

// File: tb/tb_clearable_ram.sv
// Directed bench for clearable_ram at WIDTH=16, ADDR_BITS=4.
module tb_clearable_ram;

   localparam int W     = 16;
   localparam int AB    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  in;
   logic          load;
   logic [AB-1:0] address;
   logic          clear;
   logic [W-1:0]  out;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_fail   = 0;

   clearable_ram #(
      .WIDTH     (W),
      .ADDR_BITS (AB)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .in      (in),
      .load    (load),
      .address (address),
      .clear   (clear),
      .out     (out),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [AB-1:0] a, input logic [W-1:0] d);
      address = a;
      in      = d;
      load    = 1'b1;
      tick();
      load    = 1'b0;
   endtask

   // Counts busy cycles from the acceptance edge; returns sitting in the done cycle.
   task automatic run_sweep(input string tag, input int exp_len, input bit poke);
      int n = 0;
      while (busy === 1'b1 && n < 100) begin
         if (poke && n == 5) begin
            address = 5;
            #1;
            check({tag, "_busy_out"}, 32'(out), 32'h0);
            address = 3;
            in      = 16'h1234;
            load    = 1'b1;
            clear   = 1'b1;
         end
         if (poke && n == 6) begin
            load  = 1'b0;
            clear = 1'b0;
         end
         n++;
         tick();
      end
      load  = 1'b0;
      clear = 1'b0;
      check({tag, "_len"}, 32'(n), 32'(exp_len));
      check({tag, "_done"}, 32'(done), 32'h1);
      check({tag, "_busy_end"}, 32'(busy), 32'h0);
      address = 3;
      #1;
      check({tag, "_a3"}, 32'(out), 32'h0);
      address = 5;
      #1;
      check({tag, "_a5"}, 32'(out), 32'h0);
   endtask

   task automatic read_all_zero(input string tag);
      int nz = 0;
      for (int a = 0; a < DEPTH; a++) begin
         address = AB'(a);
         #1;
         if (out !== '0) nz++;
      end
      check(tag, 32'(nz), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      int bad;
      reset   = 1'b1;
      in      = '0;
      load    = 1'b0;
      address = '0;
      clear   = 1'b0;

      // One-cycle reset starts a full sweep
      tick();
      reset = 1'b0;
      check("rst_busy", 32'(busy), 32'h1);
      check("rst_done", 32'(done), 32'h0);
      check("rst_out", 32'(out), 32'h0);
      run_sweep("rst", 16, 1'b0);
      tick();
      check("rst_done_fall", 32'(done), 32'h0);
      read_all_zero("rst_zero");

      // Zero-latency read after a user write
      address = 5;
      #1;
      check("pre_wr5", 32'(out), 32'h0);
      write_word(4'd5, 16'hBEEF);
      check("wr5", 32'(out), 32'hBEEF);
      address = 6;
      #1;
      check("rd6", 32'(out), 32'h0);
      write_word(4'd15, 16'h8001);
      check("wr15", 32'(out), 32'h8001);
      address = 5;
      #1;
      check("rd5_kept", 32'(out), 32'hBEEF);

      // Sweep with a load and a clear poked in the middle
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_busy", 32'(busy), 32'h1);
      run_sweep("clr", 16, 1'b1);

      // Clear accepted in the done cycle
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("redo_busy", 32'(busy), 32'h1);
      check("redo_done", 32'(done), 32'h0);
      run_sweep("redo", 16, 1'b0);
      tick();
      check("redo_done_fall", 32'(done), 32'h0);
      read_all_zero("redo_zero");

      // Clear and load on the same edge: clear wins
      write_word(4'd2, 16'h5555);
      check("wr2", 32'(out), 32'h5555);
      clear   = 1'b1;
      load    = 1'b1;
      address = 2;
      in      = 16'hAAAA;
      tick();
      clear = 1'b0;
      load  = 1'b0;
      check("cl_ld_busy", 32'(busy), 32'h1);
      run_sweep("cl_ld", 16, 1'b0);
      tick();
      address = 2;
      #1;
      check("cl_ld_a2", 32'(out), 32'h0);

      // Reset mid-sweep restarts it, held for three edges
      write_word(4'd15, 16'hFFFF);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      bad = 0;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (busy !== 1'b1 || done !== 1'b0) bad++;
      end
      check("pre_abort", 32'(bad), 32'h0);
      reset = 1'b1;
      tick();
      tick();
      tick();
      reset = 1'b0;
      check("abort_busy", 32'(busy), 32'h1);
      check("abort_done", 32'(done), 32'h0);
      check("abort_out", 32'(out), 32'h0);
      run_sweep("abort", 16, 1'b0);
      tick();
      check("abort_done_fall", 32'(done), 32'h0);
      read_all_zero("abort_zero");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
